// File: rtl/srt_pkg.sv
// Shared definitions for the radix-4 SRT divider: quotient-digit codes
// produced by qds and the on-the-fly converter state encoding.
package srt_pkg;

    localparam logic [2:0] QD_Z  = 3'b000;
    localparam logic [2:0] QD_P1 = 3'b001;
    localparam logic [2:0] QD_P2 = 3'b010;
    localparam logic [2:0] QD_N1 = 3'b111;
    localparam logic [2:0] QD_N2 = 3'b110;
    // Negative zero: legal, converts like QD_Z.
    localparam logic [2:0] QD_NZ = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_FIN = 2'd2,
        ST_DONE     = 2'd3
    } otf_state_e;

endpackage

// File: rtl/otf_step.sv
// One on-the-fly conversion step: appends a radix-4 signed digit to the
// Q / QM register pair (QM = Q - 1 ulp) without any carry propagation.
module otf_step
    import srt_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [2:0]   digit,
    output logic [W-1:0] q_nxt,
    output logic [W-1:0] qm_nxt,
    output logic         illegal
);

    always_comb begin
        // Digit 0: Q appends 0, QM appends 3 (borrow kept in QM).
        q_nxt   = {q[W-3:0], 2'b00};
        qm_nxt  = {qm[W-3:0], 2'b11};
        illegal = 1'b0;
        case (digit)
            QD_P1: begin
                q_nxt  = {q[W-3:0], 2'b01};
                qm_nxt = {q[W-3:0], 2'b00};
            end
            QD_P2: begin
                q_nxt  = {q[W-3:0], 2'b10};
                qm_nxt = {q[W-3:0], 2'b01};
            end
            QD_N1: begin
                q_nxt  = {qm[W-3:0], 2'b11};
                qm_nxt = {qm[W-3:0], 2'b10};
            end
            QD_N2: begin
                q_nxt  = {qm[W-3:0], 2'b10};
                qm_nxt = {qm[W-3:0], 2'b01};
            end
            QD_Z, QD_NZ: begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/otf_quo_conv.sv
// On-the-fly quotient converter: accumulates NDIGITS signed radix-4 digits,
// applies the negative-remainder correction and hands the quotient out.
module otf_quo_conv
    import srt_pkg::*;
#(
    parameter int NDIGITS = 16,
    parameter int W       = 2 * NDIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [2:0]   digit,
    output logic         digit_ready,
    input  logic         fin_valid,
    input  logic         rem_neg,
    output logic         quo_valid,
    input  logic         quo_ready,
    output logic [W-1:0] quotient,
    output logic         busy,
    output logic         err
);

    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

    // Handshakes: a digit transfers on a rising edge with digit_valid &
    // digit_ready; the result transfers on a rising edge with quo_valid &
    // quo_ready. Neither valid waits on its ready.

    otf_state_e    state;
    otf_state_e    state_nxt;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  qm_reg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q_nxt;
    logic [W-1:0]  qm_nxt;
    logic          illegal;
    logic          accept;

    otf_step #(.W(W)) u_step (
        .q       (q_reg),
        .qm      (qm_reg),
        .digit   (digit),
        .q_nxt   (q_nxt),
        .qm_nxt  (qm_nxt),
        .illegal (illegal)
    );

    assign accept = (state == ST_RUN) && digit_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_RUN;
            ST_RUN:      if (accept && (cnt == LAST_CNT)) state_nxt = ST_WAIT_FIN;
            ST_WAIT_FIN: if (fin_valid) state_nxt = ST_DONE;
            ST_DONE:     if (quo_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        digit_ready = (state == ST_RUN);
        quo_valid   = (state == ST_DONE);
        busy        = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= '0;
            qm_reg   <= '1;
            cnt      <= '0;
            quotient <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_reg  <= '0;
                        qm_reg <= '1;
                        cnt    <= '0;
                        err    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (digit_valid) begin
                        q_reg  <= q_nxt;
                        qm_reg <= qm_nxt;
                        cnt    <= cnt + CW'(1);
                    end
                    // Remainder sign is meaningless before the last digit.
                    if ((digit_valid && illegal) || fin_valid) begin
                        err <= 1'b1;
                    end
                end
                ST_WAIT_FIN: begin
                    if (fin_valid) begin
                        quotient <= rem_neg ? qm_reg : q_reg;
                    end
                    if (digit_valid) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otf_quo_conv.sv
// Bench for otf_quo_conv (NDIGITS = 4): directed scenarios plus random runs,
// scored against an arithmetic model of the signed-digit quotient value.
module tb_otf_quo_conv;

    localparam int ND = 4;
    localparam int W  = 2 * ND;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         digit_valid;
    logic [2:0]   digit;
    logic         digit_ready;
    logic         fin_valid;
    logic         rem_neg;
    logic         quo_valid;
    logic         quo_ready;
    logic [W-1:0] quotient;
    logic         busy;
    logic         err;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    logic [W-1:0] mon_exp;
    logic         mon_err;

    otf_quo_conv #(.NDIGITS(ND)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .fin_valid   (fin_valid),
        .rem_neg     (rem_neg),
        .quo_valid   (quo_valid),
        .quo_ready   (quo_ready),
        .quotient    (quotient),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp_v);
        end
    endtask

    // Reference model: signed radix-4 digit value and the quotient as an integer.
    function automatic int dval(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b111:  return -1;
            3'b110:  return -2;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [2:0] c);
        return (c == 3'b011) || (c == 3'b101);
    endfunction

    function automatic int prefix_val(input logic [11:0] codes, input int k);
        int v = 0;
        for (int i = 0; i < k; i++) v = v * 4 + dval(codes[11-3*i -: 3]);
        return v;
    endfunction

    function automatic logic [31:0] mod_w(input int v);
        logic [W-1:0] r;
        r = W'(v);
        return 32'(r);
    endfunction

    // Scoreboard monitor: compares whenever a result handshake is seen.
    always @(negedge clk) begin
        if (!rst && quo_valid && quo_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %0h required none", quotient);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_err = exp_err_q.pop_front();
                check("quotient", 32'(quotient), 32'(mon_exp));
                check("err_at_result", 32'(err), 32'(mon_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("digit_ready_after_start", 32'(digit_ready), 32'd1);
        check("err_cleared_by_start", 32'(err), 32'd0);
    endtask

    task automatic send_digit(input logic [2:0] c, input int bubbles);
        repeat (bubbles) tick();
        check("digit_ready_in_run", 32'(digit_ready), 32'd1);
        digit_valid = 1'b1;
        digit = c;
        tick();
        digit_valid = 1'b0;
        digit = 3'b000;
    endtask

    task automatic finish_conv(input int v, input logic rn, input logic e);
        check("digit_ready_after_last", 32'(digit_ready), 32'd0);
        check("busy_in_wait_fin", 32'(busy), 32'd1);
        exp_q.push_back(W'(v - (rn ? 1 : 0)));
        exp_err_q.push_back(e);
        fin_valid = 1'b1;
        rem_neg = rn;
        tick();
        fin_valid = 1'b0;
        rem_neg = 1'b0;
        check("quo_valid_after_fin", 32'(quo_valid), 32'd1);
    endtask

    task automatic drain(input int ready_delay);
        int n = 0;
        quo_ready = 1'b0;
        repeat (ready_delay) tick();
        quo_ready = 1'b1;
        tick();
        while (quo_valid && n < 10) begin
            tick();
            n++;
        end
        quo_ready = 1'b0;
        check("quo_valid_dropped", 32'(quo_valid), 32'd0);
        check("idle_after_handshake", 32'(busy), 32'd0);
    endtask

    task automatic run_conv(input logic [11:0] codes, input logic rn, input int max_bubble,
                            input int ready_delay, input bit check_prefix);
        logic [2:0] c;
        logic       e = 1'b0;
        start_pulse();
        for (int i = 0; i < ND; i++) begin
            c = codes[11-3*i -: 3];
            if (is_illegal(c)) e = 1'b1;
            send_digit(c, (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0);
            if (check_prefix) begin
                check("q_after_digit", 32'(dut.q_reg), mod_w(prefix_val(codes, i + 1)));
                check("qm_after_digit", 32'(dut.qm_reg), mod_w(prefix_val(codes, i + 1) - 1));
            end
        end
        finish_conv(prefix_val(codes, ND), rn, e);
        drain(ready_delay);
    endtask

    localparam logic [11:0] MIXED = {3'b010, 3'b001, 3'b000, 3'b111};

    initial begin
        logic [2:0]  pool [12];
        logic [11:0] codes;
        logic [W-1:0] held;
        int v;

        pool = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b110, 3'b100,
                 3'b001, 3'b010, 3'b111, 3'b110, 3'b011, 3'b101};
        rst = 1'b1;
        start = 1'b0;
        digit_valid = 1'b0;
        digit = 3'b000;
        fin_valid = 1'b0;
        rem_neg = 1'b0;
        quo_ready = 1'b0;
        #12;
        check("reset_digit_ready", 32'(digit_ready), 32'd0);
        check("reset_quo_valid", 32'(quo_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Mixed digits, both remainder signs, with per-digit register checks.
        run_conv(MIXED, 1'b0, 0, 0, 1'b1);
        run_conv(MIXED, 1'b1, 0, 0, 1'b1);
        run_conv({3'b010, 3'b010, 3'b010, 3'b010}, 1'b0, 0, 0, 1'b1);
        run_conv({3'b001, 3'b110, 3'b110, 3'b110}, 1'b0, 0, 0, 1'b1);
        run_conv({3'b001, 3'b011, 3'b001, 3'b000}, 1'b0, 0, 0, 1'b1);
        run_conv({3'b100, 3'b001, 3'b100, 3'b010}, 1'b0, 0, 1, 1'b0);

        // Backpressure: result held stable, start in DONE ignored.
        start_pulse();
        for (int i = 0; i < ND; i++) send_digit(MIXED[11-3*i -: 3], 0);
        finish_conv(prefix_val(MIXED, ND), 1'b0, 1'b0);
        held = quotient;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("bp_quo_valid", 32'(quo_valid), 32'd1);
            check("bp_quotient_stable", 32'(quotient), 32'(held));
        end
        start = 1'b0;
        drain(0);
        check("bp_err_after_start_in_done", 32'(err), 32'd0);

        // Reset mid-run: outputs drop asynchronously.
        start_pulse();
        send_digit(3'b010, 0);
        send_digit(3'b001, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_digit_ready", 32'(digit_ready), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_conv(MIXED, 1'b0, 0, 0, 1'b1);

        // Extra digit in WAIT_FIN: flagged, Q untouched.
        start_pulse();
        for (int i = 0; i < ND; i++) send_digit(MIXED[11-3*i -: 3], 0);
        digit_valid = 1'b1;
        digit = 3'b010;
        tick();
        digit_valid = 1'b0;
        check("extra_digit_err", 32'(err), 32'd1);
        check("extra_digit_q", 32'(dut.q_reg), mod_w(prefix_val(MIXED, ND)));
        finish_conv(prefix_val(MIXED, ND), 1'b0, 1'b1);
        drain(0);

        // fin_valid while still in RUN: flagged, no result.
        start_pulse();
        fin_valid = 1'b1;
        tick();
        fin_valid = 1'b0;
        check("early_fin_err", 32'(err), 32'd1);
        check("early_fin_no_valid", 32'(quo_valid), 32'd0);
        for (int i = 0; i < ND; i++) send_digit(MIXED[11-3*i -: 3], 0);
        finish_conv(prefix_val(MIXED, ND), 1'b1, 1'b1);
        drain(1);

        // Random runs: digits incl. -0 and illegal codes, bubbles, backpressure.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < ND; i++) codes[11-3*i -: 3] = pool[$urandom_range(0, 11)];
            run_conv(codes, 1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
